ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit: producer side of the decoder's `instruction` input.
//  Owns the PC and issues one word-aligned fetch to instruction memory at a time.
//  Presents each fetched word plus its PC to the decoder over a valid/ready handshake.
//  Takes redirects (jal/jalr/branch/ecall/mret targets) from execute and discards stale fetches.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  ADDR_W     32             PC / memory address width
// PORTS
//  clk             in   1       single clock, all state on rising edge
//  rst             in   1       synchronous, active-high reset
//  req_valid       out  1       fetch request valid
//  req_ready       in   1       memory accepts request
//  req_addr        out  ADDR_W  fetch address (bits [1:0] always 0)
//  resp_valid      in   1       fetch data valid (exactly one per accepted request)
//  resp_data       in   32      fetched instruction word
//  inst_valid      out  1       instruction available to decoder
//  inst_ready      in   1       decoder/execute consumes instruction
//  instruction     out  32      held instruction word
//  inst_pc         out  ADDR_W  PC of `instruction`
//  redirect_valid  in   1       execute-stage PC redirect
//  redirect_pc     in   ADDR_W  redirect target
//  misalign_err    out  1       1-cycle pulse: redirect_pc[1:0] != 0
//  fetch_cnt       out  32      count of instructions consumed (inst_valid & inst_ready, not redirected)
// BEHAVIOUR
//  Reset values: state=S_REQ, pc=RESET_PC, drop=0, req_valid=0 during reset, inst_valid=0,
//   instruction=0, inst_pc=0, misalign_err=0, fetch_cnt=0.
//   First request is asserted in the cycle after rst is released.
//  FSM:
//   S_REQ:  req_valid=1, req_addr=pc.
//           req_valid & req_ready -> S_WAIT; inflight_pc<=pc.
//   S_WAIT: no request is issued.
//           resp_valid & !drop -> capture instruction=resp_data, inst_pc=inflight_pc; go to S_HOLD.
//           resp_valid & drop -> discard, drop<=0, go to S_REQ.
//   S_HOLD: inst_valid=1, with instruction and inst_pc stable.
//           inst_valid & inst_ready -> pc<=inst_pc+4 (wraps mod 2^ADDR_W), fetch_cnt++, go to S_REQ.
//  Latency: req accepted at cycle N, resp at N+k -> inst_valid at N+k+1. Minimum loop is 3 cycles per instruction.
//  Request stability: once req_valid is high, req_addr holds until req_ready. A redirect never changes req_addr mid-request.
//  Redirect (any state), pc<=redirect_pc & ~3; last redirect wins:
//   S_REQ, no handshake: drop<=1; the current request still completes and its response is discarded.
//   S_REQ, handshake same cycle: go to S_WAIT with drop<=1.
//   S_WAIT: drop<=1. If resp_valid in the same cycle, discard it and go to S_REQ; drop ends 0.
//   S_HOLD: inst_valid falls next cycle and the held word is discarded; fetch_cnt is not incremented,
//    even if inst_ready is high; go to S_REQ.
//   redirect_pc[1:0]!=0: misalign_err=1 for the next cycle only; the target is still taken, aligned.
//  In S_REQ after a drop, the next request uses the redirected pc.
//  fetch_cnt wraps 32'hFFFF_FFFF -> 0.
//  Reset mid-operation: all state returns to reset values in the next cycle. An in-flight memory
//   response arriving after reset (state S_REQ) is ignored.
//  resp_valid outside S_WAIT is ignored (protocol error, no state change).
// TESTING
//  T1 reset: hold rst 3 cycles, zero-latency memory -> req_addr=0x80000000 on the first request;
//   inst_pc sequence 0x80000000, 0x80000004, 0x80000008.
//  T2 backpressure: inst_ready=0 for 5 cycles in S_HOLD -> instruction/inst_pc stable,
//   no new req_valid, fetch_cnt unchanged.
//  T3 redirect in S_WAIT, redirect_pc=0x80000100, response 2 cycles later -> response dropped,
//   next req_addr=0x80000100, then inst_pc=0x80000100.
//  T4 redirect in S_HOLD with inst_ready=1 the same cycle -> fetch_cnt not incremented;
//   next req_addr = redirect target.
//  T5 redirect_pc=0x80000102 -> misalign_err pulses for 1 cycle; next req_addr=0x80000100.
//  T6 req_ready held low 4 cycles, redirect in cycle 2 -> req_addr stays at the old pc until accepted;
//   that response is discarded; the following request uses the new target.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Owns the PC, keeps at most one fetch outstanding to instruction memory, and
// hands each fetched word (with its PC) to the decoder. Execute-stage redirects
// retarget the PC and cause any fetch issued under the old PC to be thrown away.
//
// Handshake rule (request, response-to-decoder): a transfer happens on a rising
// clock edge where both valid and ready are high. Once valid is raised, it and
// its payload (req_addr / instruction / inst_pc) stay constant until that
// transfer happens. The only exception is the decoder side, where a redirect
// withdraws inst_valid without a transfer. resp_valid has no ready: memory
// returns exactly one response per accepted request.
module ifu_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    // instruction memory request channel
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    // instruction memory response channel
    input  logic              resp_valid,
    input  logic [31:0]       resp_data,
    // decoder channel
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] inst_pc,
    // execute-stage redirect
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    // status
    output logic              misalign_err,
    output logic [31:0]       fetch_cnt,
    // current FSM state for observation
    output logic [1:0]        dbg_state
);

    // S_REQ : request presented to memory
    // S_WAIT: request accepted, waiting for the single response
    // S_HOLD: word captured and offered to the decoder
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    state_t            r_state;
    state_t            w_state_nxt;

    // r_pc is the architectural next-fetch PC. r_req_addr is the address of the
    // request currently presented; it only differs from r_pc when a redirect
    // arrives while a request is waiting for req_ready, because that request
    // must keep its address until accepted.
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_drop;
    logic [31:0]       r_instruction;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_misalign;
    logic [31:0]       r_fetch_cnt;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_req_addr_nxt;
    logic [ADDR_W-1:0] w_inflight_nxt;
    logic              w_drop_nxt;
    logic              w_capture;
    logic              w_consume;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic [ADDR_W-1:0] w_seq_pc;
    logic              w_redir_misaligned;

    // redirect targets are always forced to word alignment
    assign w_redir_tgt        = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // sequential successor of the word being handed to the decoder (wraps)
    assign w_seq_pc           = r_inst_pc + ADDR_W'(4);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state, datapath next values and handshake outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_addr_nxt = r_req_addr;
        w_inflight_nxt = r_inflight_pc;
        w_drop_nxt     = r_drop;
        w_capture      = 1'b0;
        w_consume      = 1'b0;
        // no request is shown while reset is held, even though the state is S_REQ
        req_valid      = (r_state == S_REQ) && !rst;
        req_addr       = r_req_addr;
        inst_valid     = (r_state == S_HOLD);

        unique case (r_state)
            S_REQ: begin
                // A redirect here cannot retract the presented request; it only
                // retargets the PC and marks the eventual response as stale.
                if (redirect_valid) begin
                    w_pc_nxt   = w_redir_tgt;
                    w_drop_nxt = 1'b1;
                end
                if (req_ready) begin
                    w_state_nxt    = S_WAIT;
                    w_inflight_nxt = r_req_addr;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_tgt;
                    if (resp_valid) begin
                        // response arriving alongside the redirect is already stale
                        w_state_nxt    = S_REQ;
                        w_drop_nxt     = 1'b0;
                        w_req_addr_nxt = w_redir_tgt;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (resp_valid) begin
                    if (r_drop) begin
                        // stale response: discard and fetch from the redirected PC
                        w_state_nxt    = S_REQ;
                        w_drop_nxt     = 1'b0;
                        w_req_addr_nxt = r_pc;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // held word is on the wrong path; drop it without counting it
                    w_state_nxt    = S_REQ;
                    w_pc_nxt       = w_redir_tgt;
                    w_req_addr_nxt = w_redir_tgt;
                end else if (inst_ready) begin
                    w_state_nxt    = S_REQ;
                    w_consume      = 1'b1;
                    w_pc_nxt       = w_seq_pc;
                    w_req_addr_nxt = w_seq_pc;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // PC, request address and drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC_ALIGNED;
            r_req_addr    <= RESET_PC_ALIGNED;
            r_inflight_pc <= '0;
            r_drop        <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_req_addr    <= w_req_addr_nxt;
            r_inflight_pc <= w_inflight_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // captured instruction word and its PC, held stable while offered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction <= '0;
            r_inst_pc     <= '0;
        end else if (w_capture) begin
            r_instruction <= resp_data;
            r_inst_pc     <= r_inflight_pc;
        end
    end

    // one-cycle misalignment flag for the redirect seen last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redir_misaligned;
        end
    end

    // count of instructions actually handed over (wraps naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
        end else if (w_consume) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign instruction  = r_instruction;
    assign inst_pc      = r_inst_pc;
    assign misalign_err = r_misalign;
    assign fetch_cnt    = r_fetch_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: drives ifu_fetch with directed scenarios and random traffic and
// checks every cycle against a transaction-level model of the fetch unit.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // clock / reset
  logic        clk;
  logic        rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign_err;
  logic [31:0] fetch_cnt;
  logic [1:0]  dbg_state;

  ifu_fetch #(
    .ADDR_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt),
    .dbg_state      (dbg_state)
  );

  // scoreboard: {pc, word} of fetches that must reach the decoder
  logic [63:0] exp_q[$];
  int          n_total;
  int          n_bad;

  // model of the fetch unit at transaction level
  logic [31:0] m_pc;        // where the next fresh request must point
  logic        m_open;      // a request is currently presented
  logic [31:0] m_req_addr;  // address of the presented request
  logic        m_out;       // a request is accepted and awaiting memory
  logic [31:0] m_out_addr;
  int          m_wait;      // cycles until memory answers
  logic        m_stale;     // a redirect hit the fetch in flight
  logic        m_hold;      // a word is offered to the decoder
  logic [31:0] m_cnt;
  logic        m_mis;
  logic        m_prev_rst;

  // instruction memory contents: fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_open  = 1'b0;
    m_req_addr = '0;
    m_out   = 1'b0;
    m_out_addr = '0;
    m_wait  = 0;
    m_stale = 1'b0;
    m_hold  = 1'b0;
    m_cnt   = '0;
    m_mis   = 1'b0;
    exp_q.delete();
  endtask

  // one clock cycle: drive inputs, check outputs, advance the model
  task automatic step(input logic a_rst, input logic a_req_ready, input logic a_inst_ready,
                      input logic a_redir, input logic [31:0] a_redir_pc, input int a_lat,
                      input logic a_spur);
    logic        resp_now;
    logic        exp_req;
    logic [63:0] front;
    @(negedge clk);
    rst            = a_rst;
    req_ready      = a_req_ready;
    inst_ready     = a_inst_ready;
    redirect_valid = a_redir && !a_rst;
    redirect_pc    = a_redir_pc;
    resp_now       = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = $urandom;
    if (!a_rst && m_out) begin
      m_wait--;
      if (m_wait == 0) begin
        resp_now   = 1'b1;
        resp_valid = 1'b1;
        resp_data  = mem_word(m_out_addr);
      end
    end else if (!a_rst && a_spur) begin
      resp_valid = 1'b1;
    end
    #1;
    exp_req = !a_rst && !m_out && !m_hold;
    check("req_valid", req_valid, exp_req);
    check("inst_valid", inst_valid, m_hold);
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("misalign_err", misalign_err, m_mis);
    if (m_hold && exp_q.size() > 0) begin
      front = exp_q[0];
      check("instruction", instruction, front[31:0]);
      check("inst_pc", inst_pc, front[63:32]);
    end
    if (a_rst && m_prev_rst) begin
      check("rst_instruction", instruction, 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
    end
    if (exp_req && req_valid) begin
      if (!m_open) check("req_addr", req_addr, m_pc);
      else         check("req_addr_hold", req_addr, m_req_addr);
    end

    m_prev_rst = a_rst;
    if (a_rst) begin
      model_reset();
      return;
    end
    m_mis = a_redir && (a_redir_pc[1:0] != 2'b00);
    if (exp_req && !m_open) begin
      m_open     = 1'b1;
      m_req_addr = m_pc;
      m_stale    = 1'b0;
    end
    if (a_redir && (m_open || m_out)) m_stale = 1'b1;
    if (m_hold && (a_redir || a_inst_ready)) begin
      front  = exp_q.pop_front();
      m_hold = 1'b0;
      if (!a_redir) begin
        m_cnt = m_cnt + 32'd1;
        m_pc  = front[63:32] + 32'd4;
      end
    end
    if (a_redir) m_pc = {a_redir_pc[31:2], 2'b00};
    if (exp_req && a_req_ready) begin
      m_open     = 1'b0;
      m_out      = 1'b1;
      m_out_addr = m_req_addr;
      m_wait     = a_lat;
    end
    if (resp_now) begin
      m_out = 1'b0;
      if (!m_stale) begin
        exp_q.push_back({m_out_addr, mem_word(m_out_addr)});
        m_hold = 1'b1;
      end
    end
  endtask

  // plain fully-ready cycle with a given memory latency
  task automatic idle(input int n, input int lat);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, lat, 1'b0);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    rst            = 1'b1;
    req_ready      = 1'b0;
    inst_ready     = 1'b0;
    resp_valid     = 1'b0;
    resp_data      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    m_prev_rst     = 1'b1;
    model_reset();

    // reset held 3 cycles, then fastest memory: PCs 0x80000000, +4, +8 ...
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1'b0);
    idle(12, 1);

    // decoder backpressure: hold a word for 5 cycles
    for (int g = 0; g < 20 && !m_hold; g++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1, 1'b0);
    idle(6, 1);

    // redirect while waiting, response lands two cycles later
    for (int g = 0; g < 20 && !m_out; g++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0100, 1, 1'b0);
    idle(10, 1);

    // redirect while holding, decoder ready in the same cycle
    for (int g = 0; g < 20 && !m_hold; g++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0040, 1, 1'b0);
    idle(8, 1);

    // misaligned redirect target
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0102, 1, 1'b0);
    idle(8, 1);

    // request stalled 4 cycles, redirect in its second cycle
    for (int g = 0; g < 20 && (m_out || m_hold); g++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0200, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    idle(10, 2);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
    idle(14, 1);

    // reset in the middle of a slow fetch
    idle(4, 4);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1, 1'b0);
    idle(10, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1, 1'b0);
      end else begin
        step(1'b0,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 99) < 8,
             32'h8000_0000 + 32'($urandom_range(0, 1023)),
             int'($urandom_range(1, 4)),
             $urandom_range(0, 19) == 0);
      end
    end
    idle(10, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
